// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator (master) and the
// text-mode pixel pipeline (slave). pix_en flows from the pipeline to the generator.
interface vga_timing_gen_if #(
  parameter int COORD_W = 11,
  parameter int COLS_W  = 7,
  parameter int ROWS_W  = 6,
  parameter int XCHAR_W = 3,
  parameter int YCHAR_W = 4
);
  logic               pix_en;
  logic               hsync;
  logic               vsync;
  logic [COORD_W-1:0] xpos;
  logic [COORD_W-1:0] ypos;
  logic               drawing;
  logic [XCHAR_W-1:0] xchar;
  logic [YCHAR_W-1:0] ychar;
  logic [COLS_W-1:0]  xtext;
  logic [ROWS_W-1:0]  ytext;
  logic               clk_load_char;
  logic               clk_load_design;
  logic               clk_draw_char;
  logic               line_start;
  logic               frame_start;
  logic               blink;

  modport master (
    input  pix_en,
    output hsync, vsync, xpos, ypos, drawing, xchar, ychar, xtext, ytext,
           clk_load_char, clk_load_design, clk_draw_char, line_start,
           frame_start, blink
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, xpos, ypos, drawing, xchar, ychar, xtext, ytext,
           clk_load_char, clk_load_design, clk_draw_char, line_start,
           frame_start, blink
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with incremental character-cell
// counters, load/draw strobes, line/frame strobes and a frame-based blink.
module vga_timing_gen #(
  parameter int H_VISIBLE         = 800,
  parameter int H_FRONT           = 56,
  parameter int H_SYNC            = 120,
  parameter int H_BACK            = 64,
  parameter int V_VISIBLE         = 600,
  parameter int V_FRONT           = 37,
  parameter int V_SYNC            = 6,
  parameter int V_BACK            = 23,
  parameter int HSYNC_ACTIVE_HIGH = 0,
  parameter int VSYNC_ACTIVE_HIGH = 0,
  parameter int CHAR_W            = 8,
  parameter int CHAR_H            = 10,
  parameter int LOAD_LEAD         = 7,
  parameter int COORD_W           = 11,
  parameter int COLS_W            = 7,
  parameter int ROWS_W            = 6,
  parameter int BLINK_FRAMES      = 32
) (
  input logic           clk,
  input logic           reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_BACK + H_VISIBLE + H_FRONT + H_SYNC;
  localparam int V_TOTAL = V_BACK + V_VISIBLE + V_FRONT + V_SYNC;
  localparam int XCW     = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int YCW     = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
  localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam bit HPOL    = (HSYNC_ACTIVE_HIGH != 0);
  localparam bit VPOL    = (VSYNC_ACTIVE_HIGH != 0);

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t HD_LO  = coord_t'(H_BACK);
  localparam coord_t HD_HI  = coord_t'(H_BACK + H_VISIBLE);
  localparam coord_t HL_LO  = coord_t'(H_BACK - LOAD_LEAD);
  localparam coord_t HL_HI  = coord_t'(H_BACK + H_VISIBLE - LOAD_LEAD);
  localparam coord_t HS_LO  = coord_t'(H_BACK + H_VISIBLE + H_FRONT);
  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t VD_LO  = coord_t'(V_BACK);
  localparam coord_t VD_HI  = coord_t'(V_BACK + V_VISIBLE);
  localparam coord_t VS_LO  = coord_t'(V_BACK + V_VISIBLE + V_FRONT);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  if (longint'(H_TOTAL) > (longint'(1) << COORD_W)) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL does not fit in COORD_W bits");
  end
  if (longint'(V_TOTAL) > (longint'(1) << COORD_W)) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL does not fit in COORD_W bits");
  end
  if (CHAR_W < 2 || CHAR_H < 1 || BLINK_FRAMES < 1 || LOAD_LEAD >= H_BACK) begin : g_param_check
    $error("vga_timing_gen: illegal CHAR_W/CHAR_H/BLINK_FRAMES/LOAD_LEAD");
  end

  coord_t            xpos, ypos;
  logic [XCW-1:0]    xcell;     // phase inside the drawn cell
  logic [XCW-1:0]    lcell;     // phase inside the load window, leads xcell by LOAD_LEAD
  logic [YCW-1:0]    ycell;
  logic [COLS_W-1:0] xtext_q;
  logic [ROWS_W-1:0] ytext_q;
  logic [FW-1:0]     frame_q;
  logic              blink_q;
  logic              load_q;

  logic   x_wrap, y_wrap, in_hd, in_hl, in_vd, drawing_c, load_cond, live;
  coord_t x_nxt, y_nxt;

  always_comb begin
    x_wrap    = (xpos == H_LAST);
    y_wrap    = (ypos == V_LAST);
    x_nxt     = x_wrap ? '0 : xpos + 1'b1;
    y_nxt     = y_wrap ? '0 : ypos + 1'b1;
    in_hd     = (xpos >= HD_LO) && (xpos < HD_HI);
    in_hl     = (xpos >= HL_LO) && (xpos < HL_HI);
    in_vd     = (ypos >= VD_LO) && (ypos < VD_HI);
    drawing_c = in_hd && in_vd;
    load_cond = in_hl && (lcell == '0);
    live      = vga.pix_en && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xpos    <= '0;
      ypos    <= '0;
      xcell   <= '0;
      lcell   <= '0;
      ycell   <= '0;
      xtext_q <= '0;
      ytext_q <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      load_q  <= 1'b0;
    end else if (vga.pix_en) begin
      xpos   <= x_nxt;
      load_q <= load_cond;
      xcell  <= (x_nxt == HD_LO || xcell == XCW'(CHAR_W - 1)) ? '0 : xcell + 1'b1;
      lcell  <= (x_nxt == HL_LO || lcell == XCW'(CHAR_W - 1)) ? '0 : lcell + 1'b1;
      if (x_nxt == HL_LO)                xtext_q <= '0;
      else if (lcell == XCW'(CHAR_W - 1)) xtext_q <= xtext_q + 1'b1;
      if (x_wrap) begin
        ypos  <= y_nxt;
        ycell <= (y_nxt == VD_LO || ycell == YCW'(CHAR_H - 1)) ? '0 : ycell + 1'b1;
        if (y_nxt == VD_LO)                 ytext_q <= '0;
        else if (ycell == YCW'(CHAR_H - 1)) ytext_q <= ytext_q + 1'b1;
        if (y_wrap) begin
          if (frame_q == FW'(BLINK_FRAMES - 1)) begin
            frame_q <= '0;
            blink_q <= ~blink_q;
          end else begin
            frame_q <= frame_q + 1'b1;
          end
        end
      end
    end
  end

  // Sync levels and strobes are forced idle while reset is held.
  always_comb begin
    vga.hsync           = HPOL ? (!reset && xpos >= HS_LO) : !(!reset && xpos >= HS_LO);
    vga.vsync           = VPOL ? (!reset && ypos >= VS_LO) : !(!reset && ypos >= VS_LO);
    vga.xpos            = xpos;
    vga.ypos            = ypos;
    vga.drawing         = !reset && drawing_c;
    vga.xchar           = vga.drawing ? xcell : '0;
    vga.ychar           = vga.drawing ? ycell : '0;
    vga.xtext           = (in_hl && in_vd) ? xtext_q : '0;
    vga.ytext           = in_vd ? ytext_q : '0;
    vga.clk_load_char   = live && load_cond;
    vga.clk_load_design = live && load_q;
    vga.clk_draw_char   = live && drawing_c && (xcell == '0);
    vga.line_start      = live && (xpos == '0);
    vga.frame_start     = live && (xpos == '0) && (ypos == '0);
    vga.blink           = blink_q;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator for the text-mode display pipeline. It is the generalised successor of the fixed 800x600@72 generator. Any mode, character-cell size and load lead is set by parameters. A pixel-clock enable allows pixel rates below clk. Character and text coordinates come from incremental counters, not dividers, and the block adds line/frame start strobes and a frame-based blink signal for the attribute logic.

Parameters:
H_VISIBLE, 800, visible pixels per line
H_FRONT, 56, horizontal front porch (pixels)
H_SYNC, 120, hsync pulse width (pixels)
H_BACK, 64, horizontal back porch (pixels)
V_VISIBLE, 600, visible lines per frame
V_FRONT, 37, vertical front porch (lines)
V_SYNC, 6, vsync pulse width (lines)
V_BACK, 23, vertical back porch (lines)
HSYNC_ACTIVE_HIGH, 0, 1 = hsync pulse is high; 0 = pulse is low
VSYNC_ACTIVE_HIGH, 0, as above for vsync
CHAR_W, 8, character cell width in pixels, >=2
CHAR_H, 10, character cell height in lines, >=1
LOAD_LEAD, 7, pixels by which character loading precedes drawing; LOAD_LEAD < H_BACK
COORD_W, 11, width of xpos/ypos
COLS_W, 7, width of xtext
ROWS_W, 6, width of ytext
BLINK_FRAMES, 32, frames per blink half-period, >=1

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous reset, active-high
pix_en  in  1  pixel advance enable; tie high for pixel rate = clk
hsync  out  1  horizontal sync, polarity per HSYNC_ACTIVE_HIGH
vsync  out  1  vertical sync, polarity per VSYNC_ACTIVE_HIGH
xpos  out  COORD_W  horizontal counter, 0..H_TOTAL-1
ypos  out  COORD_W  vertical counter, 0..V_TOTAL-1
drawing  out  1  inside the visible area
xchar  out  $clog2(CHAR_W)  pixel column inside the cell
ychar  out  $clog2(CHAR_H)  line inside the cell
xtext  out  COLS_W  text column, valid in the load window
ytext  out  ROWS_W  text row
clk_load_char  out  1  strobe: fetch character code
clk_load_design  out  1  strobe: fetch glyph row, one pixel after clk_load_char
clk_draw_char  out  1  strobe: first pixel of a drawn cell
line_start  out  1  strobe at xpos==0
frame_start  out  1  strobe at xpos==0 and ypos==0
blink  out  1  toggles every BLINK_FRAMES frames

Behaviour:
- Derived values:
  - H_TOTAL = H_BACK+H_VISIBLE+H_FRONT+H_SYNC; V_TOTAL likewise.
  - Line layout from xpos=0: back porch, visible, front porch, sync. Frame layout is the same for ypos.
  - HD = [H_BACK, H_BACK+H_VISIBLE); HL = HD shifted left by LOAD_LEAD; VD = [V_BACK, V_BACK+V_VISIBLE).
- Reset, synchronous, on any clk edge with reset=1:
  - xpos, ypos, frame counter and all cell/text counters are cleared; blink is cleared.
  - While reset is high: hsync/vsync sit at their inactive level, and drawing and all strobes are 0.
  - Reset mid-frame restarts at xpos=ypos=0 on the next edge.
- Counting:
  - Counters advance only on clk edges with pix_en=1.
  - xpos wraps from H_TOTAL-1 to 0 and then increments ypos.
  - ypos wraps from V_TOTAL-1 to 0. The wrap increments the frame counter.
  - When the frame counter reaches BLINK_FRAMES-1 it clears and toggles blink.
- Decode (combinational from registers):
  - hsync is active for xpos >= H_BACK+H_VISIBLE+H_FRONT; vsync likewise on ypos.
  - drawing = xpos in HD and ypos in VD.
- Cell counters (no divide/modulo hardware):
  - xchar = (xpos-H_BACK) mod CHAR_W while drawing, else 0.
  - ychar = (ypos-V_BACK) mod CHAR_H while drawing, else 0.
  - xtext = (xpos-(H_BACK-LOAD_LEAD))/CHAR_W while xpos in HL and ypos in VD, else 0.
  - ytext = (ypos-V_BACK)/CHAR_H while ypos in VD, else 0.
  - Counters reset at the window start and step on wrap of the inner count.
- Strobes:
  - All strobes are AND-ed with pix_en, so each pulses for exactly one clk per pixel.
  - clk_load_char: xpos in HL and (xpos-HL_start) mod CHAR_W == 0; not gated by VD.
  - clk_load_design: the same condition evaluated one pixel later (xpos-1).
  - clk_draw_char = drawing and xchar==0.
- Widths:
  - Every comparison is done at COORD_W bits.
  - Configuring H_TOTAL or V_TOTAL > 2^COORD_W is illegal and must be caught by an elaboration check.

Test Plan:
- Defaults, pix_en=1, reset 3 cycles then release -> xpos=0, ypos=0, hsync=vsync=1 during reset; frame_start=1 on the first cycle after release.
- One line -> hsync low for exactly xpos 920..1039; drawing high for xpos 64..863 on ypos=23; line_start once per 1040 clocks.
- Frame -> vsync low for ypos 660..665; frame period 1040*666 clocks; at ypos=38, xpos=64: ychar=5, ytext=1.
- Load strobes, ypos=23 -> clk_load_char at xpos 57,65,...,849 (100 pulses); clk_load_design at 58..850; xtext=0 at xpos 57, 99 at xpos 856, 0 at xpos 857.
- pix_en toggling every other clk -> xpos advances every 2 clks; every strobe is still exactly 1 clk wide; line lasts 2080 clks.
- Set BLINK_FRAMES=2, H/V shrunk to a 4+4+2+2 / 3+2+1+1 mode, run 5 frames -> blink toggles after frames 2 and 4; then assert reset mid-line at xpos=5 -> xpos=0 on the next edge, blink=0.
